// File: rtl/pcie_bar0_target_if.sv
// pcie_bar0_target_if: user-TLP bus between the ECP3 PCIe core and the BAR0 target.
// Carries the RX stream (rx_st/rx_end/rx_data/rx_bar_hit), the TX handshake and
// stream (tx_req/tx_rdy/tx_st/tx_end/tx_data) and the credit-return pulses
// (ph/pd/nph_processed). The master modport is the core side, the slave modport is the target.
interface pcie_bar0_target_if;
    logic        rx_st;
    logic        rx_end;
    logic [15:0] rx_data;
    logic [6:0]  rx_bar_hit;
    logic        tx_req;
    logic        tx_rdy;
    logic        tx_st;
    logic        tx_end;
    logic [15:0] tx_data;
    logic        ph_processed;
    logic        pd_processed;
    logic        nph_processed;
    modport master (
        output rx_st, rx_end, rx_data, rx_bar_hit, tx_rdy,
        input  tx_req, tx_st, tx_end, tx_data, ph_processed, pd_processed, nph_processed
    );
    modport slave (
        input  rx_st, rx_end, rx_data, rx_bar_hit, tx_rdy,
        output tx_req, tx_st, tx_end, tx_data, ph_processed, pd_processed, nph_processed
    );
endinterface

// File: rtl/pcie_bar0_target.sv
// pcie_bar0_target: BAR0 register target on the 16-bit user TLP interface of the ECP3 x1 PCIe core.
// Accepts 1-DW MWr32/MRd32 hitting BAR0, updates/reads a 2**NREG_LOG2 x 32-bit register
// file and answers reads with an 8-word CplD.
// Ports: clk_125/rstn (async active-low reset), tlp (RX stream, TX handshake, credit pulses),
// bus_num/dev_num/func_num (completer ID), reg0_out (register 0), err_ovf (sticky dropped-read flag).
module pcie_bar0_target #(
    parameter int NREG_LOG2 = 4
) (
    input  logic              clk_125,
    input  logic              rstn,
    pcie_bar0_target_if.slave tlp,
    input  logic [7:0]        bus_num,
    input  logic [4:0]        dev_num,
    input  logic [2:0]        func_num,
    output logic [31:0]       reg0_out,
    output logic              err_ovf
);
    localparam int NREG = 1 << NREG_LOG2;
    typedef enum logic [1:0] {R_IDLE, R_HDR, R_DATA, R_DROP} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_REQ, T_SEND} tx_state_t;
    rx_state_t rs, rs_n;
    tx_state_t ts, ts_n;
    logic [2:0] w_q, w_cur, tc;
    logic [6:0] ft_q, ft_v;
    logic bar_q, act, hdr_ok, posted, mwr_done, mrd_done, drop, pending, ovf;
    logic [15:0] req_q, dhi_q, c_req;
    logic [7:0] tag_q, c_tag;
    logic [3:0] be_q;
    logic [4:0] c_addr;
    logic [NREG_LOG2-1:0] widx_q, ridx;
    logic [31:0] wdata, c_data;
    logic [31:0] regs [NREG];
    logic [15:0] cw [8];
    logic [1:0] nph_owed;
    logic [2:0] nph_src;
    logic unused;
    assign unused = ^tlp.rx_bar_hit[6:1];
    always_comb begin
        w_cur = tlp.rx_st ? 3'd0 : w_q;
        act = tlp.rx_st || rs != R_IDLE;
        ft_v = tlp.rx_st ? tlp.rx_data[14:8] : ft_q;
        // Only consulted while word 1 (length) is on the bus.
        hdr_ok = bar_q && tlp.rx_data[9:0] == 10'd1 && (ft_q == 7'h40 || ft_q == 7'h00);
        // Memory writes and messages are posted; everything else needs non-posted credit.
        posted = (ft_v[6] && ft_v[4:0] == 5'd0) || ft_v[4:3] == 2'b10;
        mwr_done = tlp.rx_end && !tlp.rx_st && rs == R_DATA && w_q == 3'd7;
        mrd_done = tlp.rx_end && !tlp.rx_st && rs == R_HDR && w_q == 3'd5 && ft_q == 7'h00;
        drop = act && tlp.rx_end && !mwr_done && !mrd_done;
        pending = ts != T_IDLE;
        ovf = mrd_done && pending;
        ridx = tlp.rx_data[NREG_LOG2+1:2];
        wdata = {dhi_q, tlp.rx_data};
        rs_n = rs;
        if (tlp.rx_st)
            rs_n = tlp.rx_end ? R_IDLE : R_HDR;
        else if (rs != R_IDLE && tlp.rx_end)
            rs_n = R_IDLE;
        else if (rs == R_HDR && w_q == 3'd1 && !hdr_ok)
            rs_n = R_DROP;
        else if (rs == R_HDR && w_q == 3'd5)
            rs_n = ft_q == 7'h40 ? R_DATA : R_DROP;
        else if (rs == R_DATA && w_q == 3'd7)
            rs_n = R_DROP;
        ts_n = ts == T_IDLE ? (mrd_done ? T_REQ : T_IDLE) :
               ts == T_REQ  ? (tlp.tx_rdy ? T_SEND : T_REQ) :
               (tc == 3'd7 ? T_IDLE : T_SEND);
        // A dropped read's credit and a completion's credit can land together; the extra one is owed.
        nph_src = {2'b0, drop && !posted} + {2'b0, ovf} + {2'b0, ts == T_SEND && tc == 3'd6} + {1'b0, nph_owed};
        cw[0] = 16'h4A00;
        cw[1] = 16'h0001;
        cw[2] = {bus_num, dev_num, func_num};
        cw[3] = 16'h0004;
        cw[4] = c_req;
        cw[5] = {c_tag, 1'b0, c_addr, 2'b00};
        cw[6] = c_data[31:16];
        cw[7] = c_data[15:0];
    end
    assign tlp.tx_req  = ts == T_REQ;
    assign tlp.tx_st   = ts == T_SEND && tc == 3'd0;
    assign tlp.tx_end  = ts == T_SEND && tc == 3'd7;
    assign tlp.tx_data = ts == T_SEND ? cw[tc] : 16'h0000;
    assign reg0_out    = regs[0];
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            rs <= R_IDLE;
            w_q <= 3'd0;
            ft_q <= 7'd0;
            bar_q <= 1'b0;
            req_q <= 16'd0;
            tag_q <= 8'd0;
            be_q <= 4'd0;
            widx_q <= '0;
            dhi_q <= 16'd0;
        end else begin
            rs <= rs_n;
            if (act) w_q <= w_cur + 3'd1;
            if (tlp.rx_st) begin
                ft_q <= tlp.rx_data[14:8];
                bar_q <= tlp.rx_bar_hit[0];
            end
            if (act && w_cur == 3'd2) req_q <= tlp.rx_data;
            if (act && w_cur == 3'd3) begin
                tag_q <= tlp.rx_data[15:8];
                be_q <= tlp.rx_data[3:0];
            end
            if (act && w_cur == 3'd5) widx_q <= ridx;
            if (act && w_cur == 3'd6) dhi_q <= tlp.rx_data;
        end
    end
    always_ff @(posedge clk_125 or negedge rstn) begin
        if (!rstn) begin
            ts <= T_IDLE;
            tc <= 3'd0;
            for (int i = 0; i < NREG; i++) regs[i] <= 32'd0;
            c_req <= 16'd0;
            c_tag <= 8'd0;
            c_addr <= 5'd0;
            c_data <= 32'd0;
            tlp.ph_processed <= 1'b0;
            tlp.pd_processed <= 1'b0;
            tlp.nph_processed <= 1'b0;
            nph_owed <= 2'd0;
            err_ovf <= 1'b0;
        end else begin
            ts <= ts_n;
            tc <= ts == T_SEND ? tc + 3'd1 : 3'd0;
            if (mwr_done)
                for (int b = 0; b < 4; b++)
                    if (be_q[b]) regs[widx_q][8*b +: 8] <= wdata[8*b +: 8];
            // The completion snapshots the register now; later writes do not touch it.
            if (mrd_done && !pending) begin
                c_req <= req_q;
                c_tag <= tag_q;
                c_addr <= tlp.rx_data[6:2];
                c_data <= regs[ridx];
            end
            tlp.ph_processed <= mwr_done || (drop && posted);
            tlp.pd_processed <= mwr_done || (drop && posted);
            tlp.nph_processed <= nph_src != 3'd0;
            nph_owed <= nph_src == 3'd0 ? 2'd0 : 2'(nph_src - 3'd1);
            err_ovf <= err_ovf || ovf;
        end
    end
endmodule
